// File: rtl/core_pkg.sv
// Shared definitions for the pipeline stages: fetch FSM encoding,
// bubble instruction and default reset PC.
package core_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    // addi x0,x0,0
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// Generic pipeline register with enable / stall / flush priority.
// Stall beats flush so an instruction held in the next stage is never lost.
module if_id_pipe_reg
    import core_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        stall,
    input  logic        flush,
    input  logic        load_valid,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        valid_out
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;

    // Select hold / bubble / load for the next register contents
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (en && !stall) begin
            pc_d = pc_in;
            if (!flush && load_valid) begin
                inst_d  = inst_in;
                valid_d = 1'b1;
            end else begin
                inst_d  = BUBBLE_INST;
                valid_d = 1'b0;
            end
        end
    end

    // Register storage, reset to a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= 32'h0;
            inst_q  <= BUBBLE_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out    = pc_q;
    assign inst_out  = inst_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC register, imem request FSM and IF/ID register.
// A redirect that arrives while a request is outstanding is parked in a
// redirect register and the stale response is dropped when it returns.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
module if_stage_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_EN_IF,
    input  logic        reg_FD_EN,
    input  logic        reg_FD_stall,
    input  logic        reg_FD_flush,
    input  logic        Branch_ID,
    input  logic [31:0] jump_PC_ID,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] inst_in,
    output logic [31:0] PC_IF,
    output logic [31:0] PC_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_q, redirect_d;

    logic branch_taken;
    logic active;
    logic usable_rsp;

    // A branch only counts while the PC is allowed to move
    assign branch_taken = Branch_ID & PC_EN_IF;
    assign active       = (state_q == FETCH) || (state_q == WAIT);
    // Data returned together with a redirect belongs to the wrong path
    assign usable_rsp   = imem_ready & active & ~branch_taken;

    // State, PC and redirect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            redirect_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

    // Next-state logic; a redirect in FETCH restarts the fetch directly,
    // a redirect in WAIT without a response parks the target and drops
    always_comb begin
        state_d    = state_q;
        redirect_d = redirect_q;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                if (!branch_taken && !imem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ready) begin
                    state_d = FETCH;
                end else if (branch_taken) begin
                    state_d    = DROP;
                    redirect_d = jump_PC_ID;
                end
            end
            DROP: begin
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // PC update; the parked redirect is applied as soon as the stale
    // response completes, since that target was already accepted
    always_comb begin
        pc_d = pc_q;
        case (state_q)
            FETCH, WAIT: begin
                if (PC_EN_IF) begin
                    if (Branch_ID && (state_q == FETCH || imem_ready)) begin
                        pc_d = jump_PC_ID;
                    end else if (imem_ready && !Branch_ID) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            DROP: begin
                if (imem_ready) begin
                    pc_d = redirect_q;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    // Request is raised in every state except the boot cycle
    always_comb begin
        imem_req = (state_q != BOOT);
    end

    assign imem_addr = pc_q;
    assign PC_IF     = pc_q;

    if_id_pipe_reg #(
        .BUBBLE_INST (NOP_INST)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .en         (reg_FD_EN),
        .stall      (reg_FD_stall),
        .flush      (reg_FD_flush),
        .load_valid (usable_rsp),
        .pc_in      (pc_q),
        .inst_in    (inst_in),
        .pc_out     (PC_ID),
        .inst_out   (inst_ID),
        .valid_out  (valid_ID)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic        fd_load;
    logic        fetch_load;
    logic        redirect_accept;

    assign fd_load         = reg_FD_EN & ~reg_FD_stall;
    assign fetch_load      = fd_load & ~reg_FD_flush & usable_rsp;
    assign redirect_accept = branch_taken & active;

    // Saturating event counters
    always_comb begin
        fetch_cnt_d    = fetch_cnt_q;
        bubble_cnt_d   = bubble_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (fetch_load) begin
            fetch_cnt_d = sat_inc(fetch_cnt_q);
        end
        if (fd_load && !fetch_load) begin
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end
        if (redirect_accept) begin
            redirect_cnt_d = sat_inc(redirect_cnt_q);
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q    <= 32'h0;
            bubble_cnt_q   <= 32'h0;
            redirect_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q    <= fetch_cnt_d;
            bubble_cnt_q   <= bubble_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign perf_fetch_cnt    = fetch_cnt_q;
    assign perf_bubble_cnt   = bubble_cnt_q;
    assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule
